// File: rtl/rrp_stream_pkg.sv
// Shared definitions for the round-robin stream arbiter: FSM encoding,
// channel-index width helper and burst counter width.
package rrp_stream_pkg;

    // Arbiter FSM: IDLE picks the next channel, GRANT streams from it.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Burst counter holds 0..MAX_BURST with MAX_BURST up to 255.
    localparam int BURST_W = 8;

    // Width of a channel index; never below one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: returns the first requesting index strictly
// after ptr, wrapping from N-1 to 0. ptr itself is checked last.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any_req
);

    int   j;
    logic found;

    // Scan cyclically starting one past the pointer; first hit wins.
    always_comb begin
        idx     = '0;
        found   = 1'b0;
        j       = 0;
        any_req = |req;
        for (int off = 1; off <= N; off++) begin
            j = (int'(ptr) + off) % N;
            if (!found && req[j]) begin
                idx   = W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rrp_stream_arbiter.sv
// Round-robin merge of CHANNELS FWFT source FIFOs into a single
// valid/ready word stream, with enable mask, bounded bursts, frame hold,
// output backpressure and saturating per-channel word counters.
//
// Optional build macro RRP_STREAM_CHID_TAG_EN: when defined, the top
// CH_W bits of each registered word carry the source channel index.
//
// Output handshake: a word is transferred on a rising CLK edge where
// OUT_VALID and OUT_READY are both high. While OUT_VALID is high and
// OUT_READY is low, OUT_DATA/OUT_CH hold and no source pop happens.
// GRANT_ACTIVE exposes the FSM state.
module rrp_stream_arbiter
    import rrp_stream_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 16,
    localparam int CH_W      = ch_w(CHANNELS)
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic [CHANNELS-1:0]             EN_MASK,
    input  logic [CHANNELS-1:0]             FIFO_EMPTY,
    output logic [CHANNELS-1:0]             FIFO_READ,
    input  logic [CHANNELS*DATA_WIDTH-1:0]  FIFO_DATA,
    input  logic [CHANNELS-1:0]             HOLD_REQ,
    input  logic                            OUT_READY,
    output logic                            OUT_VALID,
    output logic [DATA_WIDTH-1:0]           OUT_DATA,
    output logic [CH_W-1:0]                 OUT_CH,
    output logic                            GRANT_ACTIVE,
    input  logic                            WORD_CNT_CLR,
    output logic [CHANNELS*CNT_WIDTH-1:0]   WORD_CNT
);

    localparam logic [BURST_W-1:0] MAX_B  = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] LAST_B = BURST_W'(MAX_BURST - 1);

    state_t                state, state_next;
    logic [CH_W-1:0]       rr_ptr;       // last granted channel, also current grant
    logic [BURST_W-1:0]    burst_cnt;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CH_W-1:0]       out_ch;
    logic [CNT_WIDTH-1:0]  word_cnt [CHANNELS];

    logic [CHANNELS-1:0]   req;
    logic [CH_W-1:0]       pick_idx;
    logic                  any_req;

    logic                  g_empty, g_en, g_hold;
    logic [DATA_WIDTH-1:0] g_data;
    logic [DATA_WIDTH-1:0] word_in;
    logic                  pop;
    logic                  release_grant;
    logic                  accept;

    assign req = EN_MASK & ~FIFO_EMPTY;

    rr_pick #(
        .N (CHANNELS),
        .W (CH_W)
    ) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    // Select the granted channel's flags and data.
    always_comb begin
        g_empty = FIFO_EMPTY[rr_ptr];
        g_en    = EN_MASK[rr_ptr];
        g_hold  = HOLD_REQ[rr_ptr];
        g_data  = FIFO_DATA[int'(rr_ptr)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Word as it will be registered; optionally tagged with the channel.
`ifdef RRP_STREAM_CHID_TAG_EN
    always_comb begin
        word_in = g_data;
        word_in[DATA_WIDTH-1 -: CH_W] = rr_ptr;
    end
`else
    always_comb begin
        word_in = g_data;
    end
`endif

    // Pop decision and grant release, from registered state and inputs.
    // A burst already saturated while HOLD_REQ was high also releases once
    // HOLD_REQ drops, otherwise a non-empty source could never pop again.
    always_comb begin
        pop = (state == GRANT) && !g_empty && g_en &&
              (!out_valid || OUT_READY) &&
              ((burst_cnt < MAX_B) || g_hold);
        release_grant = !g_en ||
                        (!g_hold && g_empty && !pop) ||
                        (!g_hold && pop && (burst_cnt == LAST_B)) ||
                        (!g_hold && (burst_cnt >= MAX_B));
        accept = out_valid && OUT_READY;
    end

    // One-hot pop strobe towards the granted source.
    always_comb begin
        FIFO_READ = '0;
        if (pop) begin
            FIFO_READ[rr_ptr] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = GRANT;
            GRANT:   if (release_grant) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant pointer and burst length bookkeeping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr    <= CH_W'(CHANNELS - 1);
            burst_cnt <= '0;
        end else if (state == IDLE && any_req) begin
            rr_ptr    <= pick_idx;
            burst_cnt <= '0;
        end else if (pop && burst_cnt != MAX_B) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Output register: load on pop, drop valid once consumed.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= word_in;
            out_ch    <= rr_ptr;
        end else if (OUT_READY) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating per-channel word counters; clear wins over increment.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < CHANNELS; i++) word_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (WORD_CNT_CLR) begin
                    word_cnt[i] <= '0;
                end else if (accept && out_ch == CH_W'(i) && word_cnt[i] != '1) begin
                    word_cnt[i] <= word_cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cnt_out
        assign WORD_CNT[i*CNT_WIDTH +: CNT_WIDTH] = word_cnt[i];
    end

    assign OUT_VALID    = out_valid;
    assign OUT_DATA     = out_data;
    assign OUT_CH       = out_ch;
    assign GRANT_ACTIVE = (state == GRANT);

endmodule

// File: tb/tb_rrp_stream_arbiter.sv
// Directed bench for rrp_stream_arbiter: FWFT source models, expected
// output queue filled by the stimulus thread and drained by a monitor.
module tb_rrp_stream_arbiter;

  localparam int CH = 4;
  localparam int DW = 32;
  localparam int MB = 16;
  localparam int CW = 6;

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             nRST;
  logic [CH-1:0]    EN_MASK;
  logic [CH-1:0]    FIFO_EMPTY;
  logic [CH-1:0]    FIFO_READ;
  logic [CH*DW-1:0] FIFO_DATA;
  logic [CH-1:0]    HOLD_REQ;
  logic             OUT_READY;
  logic             OUT_VALID;
  logic [DW-1:0]    OUT_DATA;
  logic [1:0]       OUT_CH;
  logic             GRANT_ACTIVE;
  logic             WORD_CNT_CLR;
  logic [CH*CW-1:0] WORD_CNT;

  rrp_stream_arbiter #(
    .CHANNELS   (CH),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .CNT_WIDTH  (CW)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .EN_MASK      (EN_MASK),
    .FIFO_EMPTY   (FIFO_EMPTY),
    .FIFO_READ    (FIFO_READ),
    .FIFO_DATA    (FIFO_DATA),
    .HOLD_REQ     (HOLD_REQ),
    .OUT_READY    (OUT_READY),
    .OUT_VALID    (OUT_VALID),
    .OUT_DATA     (OUT_DATA),
    .OUT_CH       (OUT_CH),
    .GRANT_ACTIVE (GRANT_ACTIVE),
    .WORD_CNT_CLR (WORD_CNT_CLR),
    .WORD_CNT     (WORD_CNT)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  logic [33:0] exp_q[$];          // {channel, word}
  logic [31:0] src_q[CH][$];
  logic [CH-1:0] last_rd;
  logic        last_v;
  logic        last_r;

  function automatic logic [31:0] mkw(input int c, input int t, input int j);
    return {8'(c), 8'(t), 16'(j)};
  endfunction

  function automatic logic [31:0] exp_word(input int c, input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef RRP_STREAM_CHID_TAG_EN
    r[31:30] = 2'(c);
`endif
    return r;
  endfunction

  function automatic logic [CW-1:0] cnt(input int c);
    return WORD_CNT[c*CW +: CW];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FWFT source model outputs
  task automatic refresh();
    for (int i = 0; i < CH; i++) begin
      FIFO_EMPTY[i] = (src_q[i].size() == 0);
      FIFO_DATA[i*DW +: DW] = (src_q[i].size() == 0) ? 32'h0 : src_q[i][0];
    end
  endtask

  // driver: one clock, sample strobes at negedge, pop sources after the edge
  task automatic cycle();
    @(negedge CLK);
    last_rd = FIFO_READ;
    last_v  = OUT_VALID;
    last_r  = OUT_READY;
    @(posedge CLK);
    #1;
    for (int i = 0; i < CH; i++)
      if (last_rd[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    refresh();
  endtask

  task automatic push_src(input int c, input int t, input int from, input int n);
    for (int j = from; j < from + n; j++) src_q[c].push_back(mkw(c, t, j));
    refresh();
  endtask

  task automatic push_raw(input int c, input logic [31:0] w);
    src_q[c].push_back(w);
    refresh();
  endtask

  task automatic expect_w(input int c, input int t, input int from, input int n);
    for (int j = from; j < from + n; j++)
      exp_q.push_back({2'(c), exp_word(c, mkw(c, t, j))});
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || OUT_VALID || GRANT_ACTIVE) && k < budget) begin
      cycle();
      k++;
    end
    check({"drain_", name}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clear_counters();
    WORD_CNT_CLR = 1'b1;
    cycle();
    WORD_CNT_CLR = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge CLK);
      if (nRST && OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL extra_word: got ch %0d data %0h expected no word", OUT_CH, OUT_DATA);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {30'b0, OUT_CH, OUT_DATA}, {30'b0, e});
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [3:0] pat;
    nRST = 1'b0;
    EN_MASK = '1;
    HOLD_REQ = '0;
    OUT_READY = 1'b1;
    WORD_CNT_CLR = 1'b0;
    refresh();
    #12;
    check("rst_out_valid", 64'(OUT_VALID), 64'd0);
    check("rst_out_data", 64'(OUT_DATA), 64'd0);
    check("rst_out_ch", 64'(OUT_CH), 64'd0);
    check("rst_grant", 64'(GRANT_ACTIVE), 64'd0);
    check("rst_fifo_read", 64'(FIFO_READ), 64'd0);
    check("rst_word_cnt", 64'(WORD_CNT), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // basic round robin, 3 words per channel
    for (int c = 0; c < CH; c++) push_src(c, 1, 0, 3);
    for (int c = 0; c < CH; c++) expect_w(c, 1, 0, 3);
    cycle();
    check("lat_grant", 64'(GRANT_ACTIVE), 64'd1);
    check("lat_no_valid_yet", 64'(OUT_VALID), 64'd0);
    cycle();
    check("lat_first_valid", 64'(OUT_VALID), 64'd1);
    check("lat_first_ch", 64'(OUT_CH), 64'd0);
    drain("rr", 200);
    check("rr_cnt3", 64'(cnt(3)), 64'd3);

    // burst limit: ch1 40 words, ch2 5 words
    clear_counters();
    push_src(1, 2, 0, 40);
    push_src(2, 2, 0, 5);
    expect_w(1, 2, 0, 16);
    expect_w(2, 2, 0, 5);
    expect_w(1, 2, 16, 16);
    expect_w(1, 2, 32, 8);
    drain("burst", 300);
    check("burst_cnt1", 64'(cnt(1)), 64'd40);
    check("burst_cnt2", 64'(cnt(2)), 64'd5);
    check("burst_cnt0", 64'(cnt(0)), 64'd0);

    // hold: ch0 keeps grant through empty gaps while ch3 waits
    HOLD_REQ = 4'b0001;
    expect_w(0, 3, 0, 20);
    expect_w(3, 3, 0, 2);
    for (int b = 0; b < 5; b++) begin
      push_src(0, 3, b * 4, 4);
      if (b == 0) begin
        cycle();
        push_src(3, 3, 0, 2);
      end
      repeat (14) cycle();
    end
    check("hold_grant", 64'(GRANT_ACTIVE), 64'd1);
    check("hold_ch3_waiting", 64'(src_q[3].size()), 64'd2);
    check("hold_exp_left", 64'(exp_q.size()), 64'd2);
    HOLD_REQ = '0;
    drain("hold", 100);

    // backpressure with ready pattern 1,0,0,1
    clear_counters();
    push_src(1, 4, 0, 6);
    push_src(2, 4, 0, 4);
    expect_w(1, 4, 0, 6);
    expect_w(2, 4, 0, 4);
    pat = 4'b1001;
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && !OUT_VALID && !GRANT_ACTIVE) break;
      OUT_READY = pat[k % 4];
      cycle();
      if (last_v && !last_r) check("bp_no_pop", 64'(last_rd), 64'd0);
    end
    OUT_READY = 1'b1;
    drain("bp", 50);
    check("bp_cnt1", 64'(cnt(1)), 64'd6);
    check("bp_cnt2", 64'(cnt(2)), 64'd4);

    // mask release mid-burst on ch2
    push_src(2, 5, 0, 10);
    expect_w(2, 5, 0, 3);
    cycle();
    cycle();
    cycle();
    cycle();
    EN_MASK[2] = 1'b0;
    cycle();
    check("mask_no_pop", 64'(last_rd), 64'd0);
    check("mask_release", 64'(GRANT_ACTIVE), 64'd0);
    check("mask_left", 64'(src_q[2].size()), 64'd7);

    // async reset in the middle of a ch1 transfer
    push_src(1, 6, 0, 5);
    expect_w(1, 6, 0, 1);
    cycle();
    cycle();
    cycle();
    #2;
    nRST = 1'b0;
    #1;
    check("arst_valid", 64'(OUT_VALID), 64'd0);
    check("arst_grant", 64'(GRANT_ACTIVE), 64'd0);
    check("arst_cnt", 64'(WORD_CNT), 64'd0);
    check("arst_fifo_read", 64'(FIFO_READ), 64'd0);
    EN_MASK = '1;
    push_src(0, 7, 0, 2);
    expect_w(0, 7, 0, 2);
    expect_w(1, 6, 2, 3);
    expect_w(2, 5, 3, 7);
    @(negedge CLK);
    nRST = 1'b1;
    cycle();
    cycle();
    check("post_rst_ch", 64'(OUT_CH), 64'd0);
    check("post_rst_valid", 64'(OUT_VALID), 64'd1);
    drain("post_rst", 200);

    // counter saturation and clear priority
    clear_counters();
    push_src(3, 8, 0, 70);
    expect_w(3, 8, 0, 70);
    drain("sat", 400);
    check("sat_cnt3", 64'(cnt(3)), 64'd63);
    push_src(3, 9, 0, 3);
    expect_w(3, 9, 0, 3);
    cycle();
    cycle();
    WORD_CNT_CLR = 1'b1;
    cycle();
    WORD_CNT_CLR = 1'b0;
    check("clr_prio", 64'(cnt(3)), 64'd0);
    drain("clr", 50);
    check("clr_after", 64'(cnt(3)), 64'd2);

    // all-ones source word from ch2
    push_raw(2, 32'hFFFF_FFFF);
    exp_q.push_back({2'd2, exp_word(2, 32'hFFFF_FFFF)});
    drain("tag", 50);

    repeat (3) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
